// File: rtl/alu_pkg.sv
// Shared constants, instruction layout and decode helpers for the ALU sequencer.
package alu_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned NREGS   = 4;
    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned FUNC_W  = 3;
    localparam int unsigned SHIFT_W = 3;
    localparam int unsigned STATE_W = 2;

    localparam logic [OP_W-1:0] OP_NOP   = 3'b000;
    localparam logic [OP_W-1:0] OP_ALU3  = 3'b001;
    localparam logic [OP_W-1:0] OP_ALU2  = 3'b010;
    localparam logic [OP_W-1:0] OP_SHIFT = 3'b100;

    localparam logic [FUNC_W-1:0] F3_AND  = 3'd0;
    localparam logic [FUNC_W-1:0] F3_OR   = 3'd1;
    localparam logic [FUNC_W-1:0] F3_XOR  = 3'd2;
    localparam logic [FUNC_W-1:0] F3_XNOR = 3'd3;
    localparam logic [FUNC_W-1:0] F3_ADD  = 3'd4;
    localparam logic [FUNC_W-1:0] F3_ADC  = 3'd5;
    localparam logic [FUNC_W-1:0] F3_SUB  = 3'd6;
    localparam logic [FUNC_W-1:0] F3_SBC  = 3'd7;

    localparam logic [FUNC_W-1:0] F2_NEG = 3'd0;
    localparam logic [FUNC_W-1:0] F2_NOT = 3'd1;
    localparam logic [FUNC_W-1:0] F2_SXT = 3'd2;
    localparam logic [FUNC_W-1:0] F2_SCL = 3'd3;

    localparam logic [FUNC_W-1:0] FS_SHL = 3'd0;
    localparam logic [FUNC_W-1:0] FS_SHR = 3'd1;
    localparam logic [FUNC_W-1:0] FS_SAR = 3'd2;
    localparam logic [FUNC_W-1:0] FS_ROL = 3'd3;
    localparam logic [FUNC_W-1:0] FS_ROR = 3'd4;
    localparam logic [FUNC_W-1:0] FS_RCL = 3'd5;
    localparam logic [FUNC_W-1:0] FS_RCR = 3'd6;

    localparam int unsigned INSTR_OP_LSB    = 13;
    localparam int unsigned INSTR_FUNC_LSB  = 10;
    localparam int unsigned INSTR_SHIFT_LSB = 7;
    localparam int unsigned INSTR_RD_LSB    = 5;
    localparam int unsigned INSTR_RS0_LSB   = 3;
    localparam int unsigned INSTR_RS1_LSB   = 1;
    localparam int unsigned INSTR_RSVD_BIT  = 0;

    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 0;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_READ = 2'd1;
    localparam logic [STATE_W-1:0] ST_EXEC = 2'd2;
    localparam logic [STATE_W-1:0] ST_WB   = 2'd3;

    // Instruction word minus the reserved LSB.
    typedef struct packed {
        logic [OP_W-1:0]    op_type;
        logic [FUNC_W-1:0]  func;
        logic [SHIFT_W-1:0] shift_ni;
        logic [ADDR_W-1:0]  rd;
        logic [ADDR_W-1:0]  rs0;
        logic [ADDR_W-1:0]  rs1;
    } instr_t;

    function automatic logic op_writes_back(input logic [OP_W-1:0] op);
        return (op == OP_ALU3) || (op == OP_ALU2) || (op == OP_SHIFT);
    endfunction

    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return !op_writes_back(op) && (op != OP_NOP);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4x16 register file: two operand read ports, one debug read port,
// and writeback/load write ports where writeback wins on the same address.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              ld_en_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic [ADDR_W-1:0] rd0_addr_i,
    output logic [DATA_W-1:0] rd0_data_o,
    input  logic [ADDR_W-1:0] rd1_addr_i,
    output logic [DATA_W-1:0] rd1_data_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wb_en_i && (wb_addr_i == ADDR_W'(i))) begin
                    regs_q[i] <= wb_data_i;
                end else if (ld_en_i && (ld_addr_i == ADDR_W'(i))) begin
                    regs_q[i] <= ld_data_i;
                end
            end
        end
    end

    assign rd0_data_o = regs_q[rd0_addr_i];
    assign rd1_data_o = regs_q[rd1_addr_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Four-phase issue/writeback controller for an external combinational ALU;
// owns the register file and the architectural CVZN flags.
module alu_sequencer
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [DATA_W-1:0]  alu_A,
    output logic [DATA_W-1:0]  alu_B,
    output logic               alu_cin,
    output logic [OP_W-1:0]    alu_op_type,
    output logic [FUNC_W-1:0]  alu_func,
    output logic [SHIFT_W-1:0] alu_shift_ni,
    input  logic [DATA_W-1:0]  alu_S,
    input  logic [FLAG_W-1:0]  alu_CVZN,
    input  logic               ld_en,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0]  ld_data,
    input  logic [ADDR_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [FLAG_W-1:0]  flags,
    output logic               done,
    output logic               illegal
);

    logic [STATE_W-1:0] state_q, state_d;
    instr_t             instr_q, instr_d;
    logic [DATA_W-1:0]  alu_a_q, alu_a_d;
    logic [DATA_W-1:0]  alu_b_q, alu_b_d;
    logic               alu_cin_q, alu_cin_d;
    logic [OP_W-1:0]    alu_op_q, alu_op_d;
    logic [FUNC_W-1:0]  alu_func_q, alu_func_d;
    logic [SHIFT_W-1:0] alu_shift_q, alu_shift_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic [FLAG_W-1:0]  cvzn_q, cvzn_d;
    logic [FLAG_W-1:0]  flags_q, flags_d;
    logic               done_q, done_d;
    logic               illegal_q, illegal_d;
    logic               ready_q, ready_d;

    logic               wb_en_c;
    logic [DATA_W-1:0]  rd0_data_c;
    logic [DATA_W-1:0]  rd1_data_c;
    logic               unused_rsvd;

    assign unused_rsvd = instr[INSTR_RSVD_BIT];
    assign wb_en_c     = (state_q == ST_WB) && op_writes_back(instr_q.op_type);

    alu_regfile u_regfile (
        .clk_i      (clk),
        .rst_i      (rst),
        .wb_en_i    (wb_en_c),
        .wb_addr_i  (instr_q.rd),
        .wb_data_i  (res_q),
        .ld_en_i    (ld_en),
        .ld_addr_i  (ld_addr),
        .ld_data_i  (ld_data),
        .rd0_addr_i (instr_q.rs0),
        .rd0_data_o (rd0_data_c),
        .rd1_addr_i (instr_q.rs1),
        .rd1_data_o (rd1_data_c),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            alu_op_q    <= '0;
            alu_func_q  <= '0;
            alu_shift_q <= '0;
            res_q       <= '0;
            cvzn_q      <= '0;
            flags_q     <= '0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            alu_op_q    <= alu_op_d;
            alu_func_q  <= alu_func_d;
            alu_shift_q <= alu_shift_d;
            res_q       <= res_d;
            cvzn_q      <= cvzn_d;
            flags_q     <= flags_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
            ready_q     <= ready_d;
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cin_d   = alu_cin_q;
        alu_op_d    = alu_op_q;
        alu_func_d  = alu_func_q;
        alu_shift_d = alu_shift_q;
        res_d       = res_q;
        cvzn_d      = cvzn_q;
        flags_d     = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr_t'(instr[INSTR_W-1:INSTR_RS1_LSB]);
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                alu_a_d     = rd0_data_c;
                alu_b_d     = rd1_data_c;
                alu_cin_d   = flags_q[FLAG_C];
                alu_op_d    = instr_q.op_type;
                alu_func_d  = instr_q.func;
                alu_shift_d = instr_q.shift_ni;
                state_d     = ST_EXEC;
            end
            ST_EXEC: begin
                res_d   = alu_S;
                cvzn_d  = alu_CVZN;
                state_d = ST_WB;
            end
            ST_WB: begin
                if (op_writes_back(instr_q.op_type)) begin
                    flags_d = cvzn_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d   = (state_d == ST_IDLE);
        done_d    = (state_d == ST_WB);
        illegal_d = (state_d == ST_WB) && op_is_illegal(instr_d.op_type);
    end

    assign instr_ready  = ready_q;
    assign alu_A        = alu_a_q;
    assign alu_B        = alu_b_q;
    assign alu_cin      = alu_cin_q;
    assign alu_op_type  = alu_op_q;
    assign alu_func     = alu_func_q;
    assign alu_shift_ni = alu_shift_q;
    assign flags        = flags_q;
    assign done         = done_q;
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small ALU model covering ADD/ADC.
module tb_alu_sequencer;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] alu_A, alu_B;
    logic        alu_cin;
    logic [2:0]  alu_op_type, alu_func, alu_shift_ni;
    logic [15:0] alu_S;
    logic [3:0]  alu_CVZN;
    logic        ld_en;
    logic [1:0]  ld_addr;
    logic [15:0] ld_data;
    logic [1:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [3:0]  flags;
    logic        done;
    logic        illegal;

    int n_checks = 0;
    int n_pass   = 0;

    alu_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .alu_A        (alu_A),
        .alu_B        (alu_B),
        .alu_cin      (alu_cin),
        .alu_op_type  (alu_op_type),
        .alu_func     (alu_func),
        .alu_shift_ni (alu_shift_ni),
        .alu_S        (alu_S),
        .alu_CVZN     (alu_CVZN),
        .ld_en        (ld_en),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
        .flags        (flags),
        .done         (done),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: ADD/ADC of op 001 add; anything else returns ~A so stray writes show up.
    always_comb begin
        logic [16:0] sum;
        logic        c, v;
        sum = '0;
        c   = 1'b0;
        v   = 1'b0;
        alu_S = ~alu_A;
        if (alu_op_type == 3'b001 && (alu_func == 3'd4 || alu_func == 3'd5)) begin
            sum   = {1'b0, alu_A} + {1'b0, alu_B} + ((alu_func == 3'd5) ? 17'(alu_cin) : 17'd0);
            alu_S = sum[15:0];
            c     = sum[16];
            v     = (alu_A[15] == alu_B[15]) && (sum[15] != alu_A[15]);
        end
        alu_CVZN = {c, v, (alu_S == 16'h0000), alu_S[15]};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] fn,
                                       input logic [1:0] rd, input logic [1:0] rs0,
                                       input logic [1:0] rs1);
        return {op, fn, 3'b000, rd, rs0, rs1, 1'b0};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Returns at the negedge of cycle 1 (READ), acceptance edge being cycle 0.
    task automatic issue(input logic [15:0] w);
        @(negedge clk);
        instr = w; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] r;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++; if (instr_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", instr_ready); else n_pass++;
        n_checks++; if ({done, illegal} !== 2'b00) $display("FAIL reset_pulses got=%b exp=00", {done, illegal}); else n_pass++;
        n_checks++; if (flags !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", flags); else n_pass++;
        n_checks++;
        if ({alu_A, alu_B, alu_cin, alu_op_type, alu_func, alu_shift_ni} !== 42'd0)
            $display("FAIL reset_alu_drive got=%h exp=0", {alu_A, alu_B, alu_cin, alu_op_type, alu_func, alu_shift_ni});
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i); #1; r = dbg_data;
            n_checks++; if (r !== 16'h0000) $display("FAIL reset_r%0d got=%h exp=0000", i, r); else n_pass++;
        end
    endtask

    task automatic test_add_overflow();
        load(2'd1, 16'h7FFF);
        load(2'd2, 16'h0001);
        issue(mk(3'b001, 3'd4, 2'd0, 2'd1, 2'd2));
        n_checks++; if (done !== 1'b0) $display("FAIL add_done_c1 got=%b exp=0", done); else n_pass++;
        @(negedge clk);
        n_checks++; if ({alu_A, alu_B} !== {16'h7FFF, 16'h0001}) $display("FAIL add_operands got=%h exp=7fff0001", {alu_A, alu_B}); else n_pass++;
        n_checks++; if ({alu_op_type, alu_func} !== 6'b001_100) $display("FAIL add_decode got=%b exp=001100", {alu_op_type, alu_func}); else n_pass++;
        n_checks++; if (instr_ready !== 1'b0) $display("FAIL add_ready_busy got=%b exp=0", instr_ready); else n_pass++;
        @(negedge clk);
        n_checks++; if ({done, illegal} !== 2'b10) $display("FAIL add_done_c3 got=%b exp=10", {done, illegal}); else n_pass++;
        @(negedge clk);
        dbg_addr = 2'd0; #1;
        n_checks++; if (dbg_data !== 16'h8000) $display("FAIL add_r0 got=%h exp=8000", dbg_data); else n_pass++;
        n_checks++; if (flags !== 4'b0101) $display("FAIL add_flags got=%b exp=0101", flags); else n_pass++;
        n_checks++; if ({instr_ready, done} !== 2'b10) $display("FAIL add_c4_status got=%b exp=10", {instr_ready, done}); else n_pass++;
    endtask

    task automatic test_adc_chain();
        load(2'd1, 16'hFFFF);
        load(2'd2, 16'h0001);
        issue(mk(3'b001, 3'd4, 2'd0, 2'd1, 2'd2));
        repeat (3) @(negedge clk);
        n_checks++; if (flags !== 4'b1010) $display("FAIL adc_first_flags got=%b exp=1010", flags); else n_pass++;
        load(2'd1, 16'h0000);
        load(2'd2, 16'h0000);
        issue(mk(3'b001, 3'd5, 2'd0, 2'd1, 2'd2));
        @(negedge clk);
        n_checks++; if (alu_cin !== 1'b1) $display("FAIL adc_cin got=%b exp=1", alu_cin); else n_pass++;
        repeat (2) @(negedge clk);
        dbg_addr = 2'd0; #1;
        n_checks++; if (dbg_data !== 16'h0001) $display("FAIL adc_r0 got=%h exp=0001", dbg_data); else n_pass++;
        n_checks++; if (flags !== 4'b0000) $display("FAIL adc_flags got=%b exp=0000", flags); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n_acc;
        n_acc = 0;
        @(negedge clk);
        instr = mk(3'b000, 3'd0, 2'd0, 2'd0, 2'd0);
        instr_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            n_checks++;
            if (instr_ready !== ((k % 4) == 0)) $display("FAIL b2b_ready_k%0d got=%b exp=%b", k, instr_ready, (k % 4) == 0);
            else n_pass++;
            if (instr_ready === 1'b1) n_acc++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        n_checks++; if (n_acc !== 3) $display("FAIL b2b_accept_count got=%0d exp=3", n_acc); else n_pass++;
    endtask

    task automatic test_illegal_nop();
        int n_done, n_ill;
        logic [15:0] exp_r [4];
        n_done = 0; n_ill = 0;
        exp_r[0] = 16'h1111; exp_r[1] = 16'h2222; exp_r[2] = 16'h3333; exp_r[3] = 16'h4444;
        do_reset();
        for (int i = 0; i < 4; i++) load(2'(i), exp_r[i]);
        issue(mk(3'b110, 3'd4, 2'd0, 2'd1, 2'd2));
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) @(negedge clk);
            n_done += int'(done); n_ill += int'(illegal);
        end
        issue(mk(3'b000, 3'd4, 2'd0, 2'd1, 2'd2));
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) @(negedge clk);
            n_done += int'(done); n_ill += int'(illegal);
        end
        n_checks++; if (n_ill !== 1) $display("FAIL ill_count got=%0d exp=1", n_ill); else n_pass++;
        n_checks++; if (n_done !== 2) $display("FAIL ill_done_count got=%0d exp=2", n_done); else n_pass++;
        n_checks++; if (flags !== 4'b0000) $display("FAIL ill_flags got=%b exp=0000", flags); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i); #1;
            n_checks++; if (dbg_data !== exp_r[i]) $display("FAIL ill_r%0d got=%h exp=%h", i, dbg_data, exp_r[i]); else n_pass++;
        end
    endtask

    task automatic test_collision();
        load(2'd0, 16'h1200);
        load(2'd1, 16'h0034);
        for (int pass = 0; pass < 2; pass++) begin
            issue(mk(3'b001, 3'd4, 2'd2, 2'd0, 2'd1));
            repeat (2) @(negedge clk);
            ld_en = 1'b1; ld_addr = (pass == 0) ? 2'd2 : 2'd3; ld_data = 16'hAAAA;
            @(negedge clk);
            ld_en = 1'b0;
            dbg_addr = 2'd2; #1;
            n_checks++; if (dbg_data !== 16'h1234) $display("FAIL coll_r2_pass%0d got=%h exp=1234", pass, dbg_data); else n_pass++;
        end
        dbg_addr = 2'd3; #1;
        n_checks++; if (dbg_data !== 16'hAAAA) $display("FAIL coll_r3 got=%h exp=aaaa", dbg_data); else n_pass++;
    endtask

    task automatic test_reset_mid_exec();
        load(2'd1, 16'h7FFF);
        load(2'd2, 16'h0001);
        issue(mk(3'b001, 3'd4, 2'd0, 2'd1, 2'd2));
        repeat (3) @(negedge clk);
        n_checks++; if (flags !== 4'b0101) $display("FAIL rst_pre_flags got=%b exp=0101", flags); else n_pass++;
        issue(mk(3'b001, 3'd4, 2'd0, 2'd1, 2'd2));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done_c3 got=%b exp=0", done); else n_pass++;
        @(negedge clk);
        n_checks++; if ({instr_ready, done, flags} !== 6'b100000) $display("FAIL rst_status got=%b exp=100000", {instr_ready, done, flags}); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i); #1;
            n_checks++; if (dbg_data !== 16'h0000) $display("FAIL rst_r%0d got=%h exp=0000", i, dbg_data); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        test_reset();
        test_add_overflow();
        test_adc_chain();
        test_back_to_back();
        test_illegal_nop();
        test_collision();
        test_reset_mid_exec();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle issue/writeback controller that drives the 16-bit ALU interface (A, B, Cin, op_type, func, shift count) and consumes its S/CVZN outputs. It accepts 16-bit instruction words over a valid/ready handshake, reads operands from an internal 4x16 register file, registers the ALU result and flags, and writes them back. It sits between instruction fetch and the combinational ALU and owns the architectural CVZN flag register.

## Interface
- No parameters. Widths are fixed: 16-bit data, 4 registers, 4-bit CVZN.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_valid` in 1: an instruction word is offered.
- `instr_ready` out 1: high only in IDLE.
- `instr` in 16: instruction word. Fields:
  - [15:13] op_type
  - [12:10] func
  - [9:7] shift_count_ni
  - [6:5] rd
  - [4:3] rs0
  - [2:1] rs1
  - [0] reserved, ignored
- `alu_A`, `alu_B` out 16 each: registered operands driven to the ALU.
- `alu_cin` out 1: registered copy of flag C.
- `alu_op_type`, `alu_func`, `alu_shift_ni` out 3 each: registered decode fields.
- `alu_S` in 16: ALU result.
- `alu_CVZN` in 4: ALU flags {C,V,Z,N}.
- `ld_en`, `ld_addr` (2), `ld_data` (16) in: external register-file load port, accepted in any state.
- `dbg_addr` in 2, `dbg_data` out 16: combinational register-file read.
- `flags` out 4: architectural CVZN register.
- `done` out 1: one-cycle pulse in WB.
- `illegal` out 1: one-cycle pulse in WB, only for an illegal op_type.

## Operation
- States: IDLE -> READ -> EXEC -> WB -> IDLE. The sequence is unconditional once an instruction is accepted.
- IDLE:
  - `instr_ready` = 1.
  - When `instr_valid` is high, latch `instr` and go to READ.
- READ:
  - `alu_A` <= reg[rs0], `alu_B` <= reg[rs1].
  - `alu_cin` <= flags[3].
  - `alu_op_type`, `alu_func`, `alu_shift_ni` <= their instruction fields.
- EXEC:
  - ALU drive outputs are held stable.
  - `alu_S` and `alu_CVZN` are sampled into internal result/flag registers at the end of the cycle.
- WB, for op_type 001, 010 or 100:
  - reg[rd] <= result; `flags` <= sampled CVZN; `done` = 1.
- WB, for op_type 000 (NOP):
  - No register or flag write; `done` = 1.
- WB, for op_type 011, 101, 110 or 111:
  - Treated as NOP; `done` = 1 and `illegal` = 1.
- The sequencer does no arithmetic itself. The result is stored bit-exact from `alu_S`.
- Register-file write priority on the same address in the same cycle: WB beats `ld_en`. Loads to any other address proceed in parallel.
- A load to rs0/rs1 in the READ cycle is not visible to that read; the old value is read.

## Timing
- Acceptance edge is cycle 0. READ, EXEC and WB are cycles 1, 2 and 3.
- Register and flag updates are visible from cycle 4. `instr_ready` returns high in cycle 4.
- Throughput is one instruction per 4 cycles. Back-to-back `instr_valid` is accepted in cycles 0, 4, 8, ...
- A dependent instruction always sees the prior result, because writeback completes before the next READ. No hazard logic is needed.
- Reset values:
  - state IDLE; all 4 registers 0x0000; `flags` 4'b0000.
  - `alu_A`, `alu_B`, `alu_cin`, `alu_op_type`, `alu_func`, `alu_shift_ni` all 0.
  - `done` 0, `illegal` 0, internal result/flag registers 0.
  - `instr_ready` 1 in the first cycle after reset deasserts.
- Reset in any state aborts the instruction: no writeback, no `done`, registers cleared.
- `instr_valid` outside IDLE is ignored. The source must hold the word until it sees `instr_ready`.

## Structure
- Shared package `alu_pkg`:
  - op_type constants OP_NOP=3'b000, OP_ALU3=3'b001, OP_ALU2=3'b010, OP_SHIFT=3'b100.
  - func constants for ALU3 (AND..SBC = 0..7), ALU2 (NEG, NOT, SXT, SCL = 0..3) and shifts (SHL..RCR = 0..6).
  - Instruction-field bit positions.
  - Flag index constants C=3, V=2, Z=1, N=0.
  - State enum.
- One natural sub-module, `alu_regfile`: 4x16 registers with two read ports, the debug read port, and two write ports with fixed WB-over-load priority.
- The FSM and decode stay in `alu_sequencer`. The ALU is instantiated alongside it at the top level, not inside it.

## Test plan
- ADD overflow:
  - Stimulus: load r1=0x7FFF, r2=0x0001; issue op 001/func 4, rd=0, rs0=1, rs1=2; ALU model returns 0x8000/4'b0101.
  - Required: r0=0x8000, `flags`=4'b0101, `done` in cycle 3.
- ADC carry chain:
  - Stimulus: ADD 0xFFFF+0x0001 (flags to 4'b1010), then ADC 0+0.
  - Required: `alu_cin`=1 in the second EXEC; r0=0x0001 after the second instruction.
- Back-to-back:
  - Stimulus: `instr_valid` held high for 12 cycles.
  - Required: exactly 3 acceptances, at cycles 0, 4 and 8; `instr_ready` low in all other cycles.
- Illegal and NOP:
  - Stimulus: op_type 3'b110, then op_type 3'b000.
  - Required: `illegal` pulses once; `done` pulses twice; registers and flags unchanged.
- WB/load collision:
  - Stimulus: `ld_en` to rd=2 with 0xAAAA in the WB cycle of an op writing 0x1234 to r2.
  - Required: r2=0x1234.
  - Stimulus: the same load, but to r3.
  - Required: r3=0xAAAA.
- Reset mid-EXEC:
  - Stimulus: `rst` asserted in cycle 2 of an ADD.
  - Required: no `done`; all registers and `flags` are 0; `instr_ready`=1 after release.
